seven_seg_reader: RTL
=====================

# seven_seg_reader

Readback monitor for the multiplexed 4-digit seven-segment bus. It samples the active-low `anode`/`segs` lines that the scanner and decoder drive, waits for each digit dwell to settle, and decodes each glyph back to a hex nibble. Once all four digits of a frame are captured, it publishes the frame atomically. It sits beside the display path, feeding on-board self-check logic and the bench scoreboard.

## Interface
- `STABLE_CYCLES`, default 4: consecutive unchanged registered samples required before a dwell is accepted; legal range 2..255.
- `clock`  in  1  system clock; all logic on the rising edge.
- `reset`  in  1  synchronous, active-low reset; `reset == 0` at a rising edge clears all state.
- `anode`  in  4  active-low digit enables; digit i is selected when only bit i is 0.
- `segs`  in  7  active-low segments, `{g,f,e,d,c,b,a}` = `segs[6:0]`.
- `digits`  out  16  last complete frame; digit i in `[4i+3:4i]`.
- `digit_valid`  out  4  bit i is set when digit i decoded to a legal hex glyph in the last frame.
- `blank`  out  4  bit i is set when digit i was all-off (`7'b1111111`) in the last frame.
- `frame_done`  out  1  one-cycle pulse on the edge that `digits`/`digit_valid`/`blank` update.
- `err`  out  1  sticky error flag (see Configuration).

## Operation
- Input stage: `anode` and `segs` register into `in_q` every cycle. A stability counter increments while `in_q` equals its previous value, and clears to 0 on any change.
- Dwell FSM, states `WAIT`, `SETTLE`, `HELD`:
  - `WAIT` → `SETTLE` when `in_q` anode is one-hot-low.
  - `SETTLE` → `HELD` when the counter reaches `STABLE_CYCLES-1`. The capture happens on this edge.
  - `SETTLE`/`HELD` → `WAIT` on any `in_q` change. This gives exactly one capture per dwell.
- Capture writes the decoded nibble, valid bit, and blank bit into shadow slot i, and sets `seen[i]`. A repeat capture of the same digit before the frame completes overwrites the slot (latest wins).
- Decode uses standard hex glyphs: `0`=`1000000`, `1`=`1111001`, `8`=`0000000`, `F`=`0001110`; `A`, `C`, `E`, `F` are upper case and `b`, `d` are lower case. The full table is in the package.
  - A non-table, non-blank pattern gives nibble 0 and valid 0.
  - A blank pattern gives nibble 0, valid 0, and blank 1.
- Frame completion: when `seen` becomes `4'b1111`, the shadow slots copy to the outputs, `frame_done` pulses, and `seen` clears.
- Anode all-high is a legal inter-digit gap: no capture and no error. More than one anode bit low is illegal: no capture, and an error event.
- Reset values: `digits`=0, `digit_valid`=0, `blank`=0, `frame_done`=0, `err`=0, `seen`=0, FSM=`WAIT`, counter=0. Reset mid-dwell or mid-frame discards partial captures.

## Timing
- The input register adds 1 cycle of latency.
- For a dwell whose pins change before edge k and then hold, the capture edge is k+`STABLE_CYCLES`. `frame_done` and the output update occur on the edge after the fourth distinct capture.
- A dwell shorter than `STABLE_CYCLES+1` edges is never captured and is not an error.
- Simultaneous frame completion and a new pin change: the completion takes effect, and the change restarts the counter.
- Outputs hold their value between frames. `frame_done` is never asserted on two consecutive cycles.

## Configuration
- `SEVEN_SEG_READER_ERR_EN` defined:
  - `err` sets on a multi-low anode or an undecodable non-blank glyph.
  - `err` stays set until reset.
  - An 8-bit saturating internal `err_count` increments per error event and is visible hierarchically.
- Undefined: `err` is tied to 0 and `err_count` is absent. Undecodable glyphs still produce valid 0.

## Structure
- Package `seven_seg_pkg`:
  - glyph constants for 0-F and blank;
  - `NUM_DIGITS`=4;
  - FSM state typedef.
  - The display decoder imports the same glyph constants, so encode and decode cannot diverge.
- One sub-module: `seven_seg_glyph_decode`, combinational, taking the 7-bit glyph and returning {nibble, valid, blank}.
- The dwell FSM, counter, and frame assembly stay in the top module.

## Test plan
- Scan 3,2,1,0 with glyphs `F`,`0`,`8`,`1`, each held 10 cycles with `STABLE_CYCLES`=4 → one `frame_done` pulse, `digits`=16'hF081, `digit_valid`=4'hF, `blank`=0.
- Digit 0 dwell of 4 cycles, then 10 cycles → exactly one capture. The short dwell is ignored, and there is no error.
- `anode`=`4'b0011` held 10 cycles → no capture; `err`=1 with the macro, 0 without.
- Digit 2 shows `1111111` within an otherwise valid frame → `blank`=4'b0100, `digit_valid`=4'b1011, nibble 2 = 0.
- Three digits captured, `reset`=0 for one cycle, then a full frame → the only `frame_done` comes after the post-reset frame, with no stale nibbles.
- Digit 1 captured as `5`, then recaptured as `7` before the frame completes → `digits[7:4]`=7.

Source files
------------

// File: rtl/seven_seg_reader_pkg.sv
// Shared seven-segment glyph table (active-low {g,f,e,d,c,b,a}) and reader FSM states.
// Used by the readback decoder; display-side encoders use glyph_of() so both sides stay aligned.
package seven_seg_pkg;

    localparam int NUM_DIGITS = 4;

    localparam logic [6:0] GLYPH_0     = 7'b1000000;
    localparam logic [6:0] GLYPH_1     = 7'b1111001;
    localparam logic [6:0] GLYPH_2     = 7'b0100100;
    localparam logic [6:0] GLYPH_3     = 7'b0110000;
    localparam logic [6:0] GLYPH_4     = 7'b0011001;
    localparam logic [6:0] GLYPH_5     = 7'b0010010;
    localparam logic [6:0] GLYPH_6     = 7'b0000010;
    localparam logic [6:0] GLYPH_7     = 7'b1111000;
    localparam logic [6:0] GLYPH_8     = 7'b0000000;
    localparam logic [6:0] GLYPH_9     = 7'b0010000;
    localparam logic [6:0] GLYPH_A     = 7'b0001000;
    localparam logic [6:0] GLYPH_B     = 7'b0000011;
    localparam logic [6:0] GLYPH_C     = 7'b1000110;
    localparam logic [6:0] GLYPH_D     = 7'b0100001;
    localparam logic [6:0] GLYPH_E     = 7'b0000110;
    localparam logic [6:0] GLYPH_F     = 7'b0001110;
    localparam logic [6:0] GLYPH_BLANK = 7'b1111111;

    typedef enum logic [1:0] {
        WAIT   = 2'd0,
        SETTLE = 2'd1,
        HELD   = 2'd2
    } dwell_state_e;

    function automatic logic [6:0] glyph_of(input logic [3:0] nibble);
        logic [6:0] g;
        case (nibble)
            4'h0: g = GLYPH_0;
            4'h1: g = GLYPH_1;
            4'h2: g = GLYPH_2;
            4'h3: g = GLYPH_3;
            4'h4: g = GLYPH_4;
            4'h5: g = GLYPH_5;
            4'h6: g = GLYPH_6;
            4'h7: g = GLYPH_7;
            4'h8: g = GLYPH_8;
            4'h9: g = GLYPH_9;
            4'hA: g = GLYPH_A;
            4'hB: g = GLYPH_B;
            4'hC: g = GLYPH_C;
            4'hD: g = GLYPH_D;
            4'hE: g = GLYPH_E;
            default: g = GLYPH_F;
        endcase
        return g;
    endfunction

endpackage

// File: rtl/seven_seg_reader_if.sv
// Display pin bus as seen by the readback monitor, plus the published frame.
// master drives the pins and consumes frames; slave is the reader.
interface seven_seg_reader_if;
    logic [3:0]  anode;
    logic [6:0]  segs;
    logic [15:0] digits;
    logic [3:0]  digit_valid;
    logic [3:0]  blank;
    logic        frame_done;
    logic        err;

    modport master (
        output anode, segs,
        input  digits, digit_valid, blank, frame_done, err
    );

    modport slave (
        input  anode, segs,
        output digits, digit_valid, blank, frame_done, err
    );
endinterface

// File: rtl/seven_seg_glyph_decode.sv
// Combinational glyph-to-nibble decoder; zero latency, no flow control.
// Non-table glyphs return nibble 0 / valid 0; all-off additionally flags blank.
module seven_seg_glyph_decode
    import seven_seg_pkg::*;
(
    input  logic [6:0] glyph_i,
    output logic [3:0] nibble_o,
    output logic       valid_o,
    output logic       blank_o
);

    always_comb begin
        nibble_o = 4'h0;
        valid_o  = 1'b0;
        blank_o  = (glyph_i == GLYPH_BLANK);
        for (int i = 0; i < 16; i++) begin
            if (glyph_i == glyph_of(4'(i))) begin
                nibble_o = 4'(i);
                valid_o  = 1'b1;
            end
        end
    end

endmodule

// File: rtl/seven_seg_reader.sv
// Seven-segment readback: 1-cycle input register, capture STABLE_CYCLES edges after a pin change.
// Passive monitor with no backpressure; SEVEN_SEG_READER_ERR_EN enables the sticky err flag and err_count.
module seven_seg_reader
    import seven_seg_pkg::*;
#(
    parameter int STABLE_CYCLES = 4
) (
    input logic           clock,
    input logic           reset,
    seven_seg_reader_if.slave bus
);

    localparam logic [7:0] CNT_TGT = 8'(STABLE_CYCLES - 1);

    logic [3:0]   anode_q;
    logic [6:0]   segs_q;
    logic [7:0]   cnt_q, cnt_d;
    dwell_state_e state_q;
    logic [3:0]   seen_q, seen_d;
    logic [15:0]  sh_dig_q, digits_q;
    logic [3:0]   sh_vld_q, sh_blk_q, valid_q, blank_q;
    logic         frame_done_q;

    logic         stable, one_hot_low, capture, frame_full;
    logic [1:0]   sel;
    logic [3:0]   dec_nib;
    logic         dec_vld, dec_blk;

    seven_seg_glyph_decode u_decode (
        .glyph_i  (segs_q),
        .nibble_o (dec_nib),
        .valid_o  (dec_vld),
        .blank_o  (dec_blk)
    );

    // The next registered sample matching the current one means in_q is unchanged.
    assign stable      = (bus.anode == anode_q) && (bus.segs == segs_q);
    assign one_hot_low = $onehot(~anode_q);
    assign capture     = (state_q == SETTLE) && stable && (cnt_q == CNT_TGT);
    assign frame_full  = (seen_q == 4'hF);

    always_comb begin
        sel = 2'd0;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (!anode_q[i]) sel = 2'(i);
        end
    end

    always_comb begin
        cnt_d = 8'd0;
        if (stable) cnt_d = (cnt_q == 8'hFF) ? cnt_q : cnt_q + 8'd1;
    end

    always_comb begin
        seen_d = frame_full ? 4'h0 : seen_q;
        if (capture) seen_d[sel] = 1'b1;
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            anode_q      <= 4'hF;
            segs_q       <= 7'h7F;
            cnt_q        <= 8'd0;
            state_q      <= WAIT;
            seen_q       <= 4'h0;
            sh_dig_q     <= 16'h0;
            sh_vld_q     <= 4'h0;
            sh_blk_q     <= 4'h0;
            digits_q     <= 16'h0;
            valid_q      <= 4'h0;
            blank_q      <= 4'h0;
            frame_done_q <= 1'b0;
        end else begin
            anode_q      <= bus.anode;
            segs_q       <= bus.segs;
            cnt_q        <= cnt_d;
            seen_q       <= seen_d;
            frame_done_q <= frame_full;

            if (!stable) begin
                state_q <= WAIT;
            end else begin
                case (state_q)
                    WAIT:    if (one_hot_low) state_q <= SETTLE;
                    SETTLE:  if (capture) state_q <= HELD;
                    HELD:    state_q <= HELD;
                    default: state_q <= WAIT;
                endcase
            end

            if (capture) begin
                sh_dig_q[sel*4 +: 4] <= dec_nib;
                sh_vld_q[sel]        <= dec_vld;
                sh_blk_q[sel]        <= dec_blk;
            end

            if (frame_full) begin
                digits_q <= sh_dig_q;
                valid_q  <= sh_vld_q;
                blank_q  <= sh_blk_q;
            end
        end
    end

    assign bus.digits      = digits_q;
    assign bus.digit_valid = valid_q;
    assign bus.blank       = blank_q;
    assign bus.frame_done  = frame_done_q;

`ifdef SEVEN_SEG_READER_ERR_EN
    logic       err_q;
    logic [7:0] err_count;
    logic       multi_event, err_event;

    // A multi-low anode counts once per dwell, when it has been held as long as a capture would need.
    assign multi_event = (state_q == WAIT) && !$onehot0(~anode_q) && stable && (cnt_q == CNT_TGT);
    assign err_event   = multi_event || (capture && !dec_vld && !dec_blk);

    always_ff @(posedge clock) begin
        if (!reset) begin
            err_q     <= 1'b0;
            err_count <= 8'd0;
        end else if (err_event) begin
            err_q <= 1'b1;
            if (err_count != 8'hFF) err_count <= err_count + 8'd1;
        end
    end

    assign bus.err = err_q;
`else
    assign bus.err = 1'b0;
`endif

endmodule
